// File: rtl/pattern_tester.sv
// pattern_tester: walks the pattern ROM, writes each memory word with its
// rotated pattern, reads every word back and records mismatches over 64 passes.
module pattern_tester #(
    parameter int ADDR_WIDTH = 18,
    parameter int MEM_WORDS  = 262144
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [5:0]            pattern_addr,
    input  logic [15:0]           pattern_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [5:0]            pass_num,
    output logic [15:0]           error_count,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [15:0]           fail_expected,
    output logic [15:0]           fail_actual
);

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_FETCH,
        W_LATCH,
        W_WAIT,
        R_FETCH,
        R_LATCH,
        R_WAIT,
        DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] wordAddr_q;
    logic [ADDR_WIDTH-1:0] wordAddr_d;
    logic [5:0]            patternAddr_q;
    logic                  memReq_q;
    logic                  memWe_q;
    logic [ADDR_WIDTH-1:0] memAddr_q;
    logic [15:0]           memWdata_q;
    logic [15:0]           expected_q;
    logic [5:0]            passNum_q;
    logic [5:0]            passNum_d;
    logic [15:0]           errorCount_q;
    logic [15:0]           errorCount_d;
    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] failAddr_q;
    logic [15:0]           failExpected_q;
    logic [15:0]           failActual_q;
    logic                  lastWord;
    logic                  mismatch;

    // The pattern for a word rotates by one ROM entry per pass; the 6-bit add wraps.
    function automatic logic [5:0] patIndex(input logic [ADDR_WIDTH-1:0] addr,
                                            input logic [5:0]            pass);
        return 6'(addr) + pass;
    endfunction

    // Next word address, next pass number, read comparison and saturating error count.
    always_comb begin
        lastWord     = (wordAddr_q == LAST_WORD);
        wordAddr_d   = lastWord ? '0 : wordAddr_q + 1'b1;
        passNum_d    = passNum_q + 6'd1;
        mismatch     = (mem_rdata != expected_q);
        errorCount_d = (errorCount_q == 16'hFFFF) ? errorCount_q : errorCount_q + 16'd1;
    end

    // Sequencer: fetch pattern, latch it, run one memory handshake, repeat per word and pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wordAddr_q     <= '0;
            patternAddr_q  <= '0;
            memReq_q       <= 1'b0;
            memWe_q        <= 1'b0;
            memAddr_q      <= '0;
            memWdata_q     <= '0;
            expected_q     <= '0;
            passNum_q      <= '0;
            errorCount_q   <= '0;
            fail_q         <= 1'b0;
            failAddr_q     <= '0;
            failExpected_q <= '0;
            failActual_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q        <= W_FETCH;
                        wordAddr_q     <= '0;
                        patternAddr_q  <= '0;
                        passNum_q      <= '0;
                        errorCount_q   <= '0;
                        fail_q         <= 1'b0;
                        failAddr_q     <= '0;
                        failExpected_q <= '0;
                        failActual_q   <= '0;
                    end
                end
                W_FETCH: begin
                    state_q <= W_LATCH;
                end
                W_LATCH: begin
                    memWdata_q <= pattern_data;
                    memAddr_q  <= wordAddr_q;
                    memWe_q    <= 1'b1;
                    memReq_q   <= 1'b1;
                    state_q    <= W_WAIT;
                end
                W_WAIT: begin
                    if (mem_ack) begin
                        memReq_q      <= 1'b0;
                        wordAddr_q    <= wordAddr_d;
                        patternAddr_q <= patIndex(wordAddr_d, passNum_q);
                        state_q       <= lastWord ? R_FETCH : W_FETCH;
                    end
                end
                R_FETCH: begin
                    state_q <= R_LATCH;
                end
                R_LATCH: begin
                    expected_q <= pattern_data;
                    memAddr_q  <= wordAddr_q;
                    memWe_q    <= 1'b0;
                    memReq_q   <= 1'b1;
                    state_q    <= R_WAIT;
                end
                R_WAIT: begin
                    if (mem_ack) begin
                        memReq_q   <= 1'b0;
                        wordAddr_q <= wordAddr_d;
                        if (mismatch) begin
                            errorCount_q <= errorCount_d;
                            if (!fail_q) begin
                                fail_q         <= 1'b1;
                                failAddr_q     <= memAddr_q;
                                failExpected_q <= expected_q;
                                failActual_q   <= mem_rdata;
                            end
                        end
                        if (!lastWord) begin
                            patternAddr_q <= patIndex(wordAddr_d, passNum_q);
                            state_q       <= R_FETCH;
                        end else if (passNum_q == 6'd63) begin
                            state_q <= DONE;
                        end else begin
                            passNum_q     <= passNum_d;
                            patternAddr_q <= patIndex(wordAddr_d, passNum_d);
                            state_q       <= W_FETCH;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    memReq_q <= 1'b0;
                end
            endcase
        end
    end

    assign pattern_addr  = patternAddr_q;
    assign mem_req       = memReq_q;
    assign mem_we        = memWe_q;
    assign mem_addr      = memAddr_q;
    assign mem_wdata     = memWdata_q;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign pass_num      = passNum_q;
    assign error_count   = errorCount_q;
    assign fail          = fail_q;
    assign fail_addr     = failAddr_q;
    assign fail_expected = failExpected_q;
    assign fail_actual   = failActual_q;

endmodule
